// File: rtl/div_unit.sv
// Sequential signed divider: one restoring shift-subtract step per clock on the
// operand magnitudes, then a sign-correction cycle that loads hi/lo.
module div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero,
  output logic [1:0]  stateDbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } divState_t;

  divState_t   state;
  divState_t   stateNext;
  logic [5:0]  stepCount;
  logic [63:0] remQuo;
  logic [31:0] divisorMag;
  logic        quoNeg;
  logic        remNeg;
  logic        divisorZero;
  logic        acceptStart;
  logic [32:0] trialDiff;
  logic [31:0] quoMag;
  logic [31:0] remMag;

  assign divisorZero = (b == 32'd0);
  assign acceptStart = (state == IDLE) && start && !divisorZero;

  // Upper remainder is always below the divisor, so a 33-bit trial is enough;
  // bit 32 set means the subtraction borrowed and the step restores.
  assign trialDiff = remQuo[63:31] - {1'b0, divisorMag};
  assign quoMag    = remQuo[31:0];
  assign remMag    = remQuo[63:32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    busy      = 1'b0;
    stateDbg  = state;
    case (state)
      IDLE: begin
        if (acceptStart) stateNext = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (stepCount == 6'd31) stateNext = FINISH;
      end
      FINISH: begin
        busy      = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stepCount  <= 6'd0;
      remQuo     <= 64'd0;
      divisorMag <= 32'd0;
      quoNeg     <= 1'b0;
      remNeg     <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      done     <= (state == FINISH);
      div_zero <= (state == IDLE) && start && divisorZero;
      case (state)
        IDLE: begin
          if (acceptStart) begin
            // Magnitude of -2^31 wraps to 0x80000000, which is correct unsigned.
            remQuo     <= {32'd0, (a[31] ? (~a + 32'd1) : a)};
            divisorMag <= b[31] ? (~b + 32'd1) : b;
            remNeg     <= a[31];
            quoNeg     <= a[31] ^ b[31];
            stepCount  <= 6'd0;
          end
        end
        RUN: begin
          stepCount <= stepCount + 6'd1;
          if (trialDiff[32]) remQuo <= {remQuo[62:0], 1'b0};
          else               remQuo <= {trialDiff[31:0], remQuo[30:0], 1'b1};
        end
        FINISH: begin
          lo <= quoNeg ? (~quoMag + 32'd1) : quoMag;
          hi <= remNeg ? (~remMag + 32'd1) : remMag;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomized and directed checks of div_unit against a 64-bit arithmetic
// reference of signed truncating division.
module tb_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [1:0]  stateDbg;

  div_unit dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero),
    .stateDbg(stateDbg)
  );

  always #5 clock = ~clock;

  int          nChecks = 0;
  int          nPass   = 0;
  logic [63:0] expQ[$];
  logic [31:0] lastHi = 32'd0;
  logic [31:0] lastLo = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got === want) nPass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
  endtask

  // {remainder, quotient} from plain signed arithmetic at 64 bits, truncated to 32.
  function automatic logic [63:0] refDiv(input logic [31:0] x, input logic [31:0] y);
    longint      sx;
    longint      sy;
    logic [63:0] q;
    logic [63:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = sx / sy;
    r  = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents one request for a single edge; inputs are then scrambled to show
  // the unit does not re-sample them.
  task automatic startDiv(input logic [31:0] x, input logic [31:0] y, input bit holdStart);
    a = x;
    b = y;
    start = 1'b1;
    expQ.push_back(refDiv(x, y));
    tick();
    if (!holdStart) start = 1'b0;
    a = $urandom;
    b = $urandom;
    check("busyAfterStart", {31'd0, busy}, 32'd1);
  endtask

  task automatic waitDone(input string tag);
    int          n;
    bit          busyGap;
    bit          zeroSeen;
    logic [63:0] exp;
    n = 0;
    busyGap = 1'b0;
    zeroSeen = 1'b0;
    while (!done && n < 40) begin
      if (!busy) busyGap = 1'b1;
      if (div_zero) zeroSeen = 1'b1;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 33);
    check({tag, "_busyHeld"}, {31'd0, busyGap}, 32'd0);
    check({tag, "_noDivZero"}, {31'd0, zeroSeen | div_zero}, 32'd0);
    check({tag, "_busyLowAtDone"}, {31'd0, busy}, 32'd0);
    if (expQ.size() == 0) begin
      check({tag, "_queueEmpty"}, 32'd1, 32'd0);
    end else begin
      exp = expQ.pop_front();
      check({tag, "_lo"}, lo, exp[31:0]);
      check({tag, "_hi"}, hi, exp[63:32]);
      lastLo = exp[31:0];
      lastHi = exp[63:32];
    end
  endtask

  task automatic doneDrops(input string tag);
    tick();
    check({tag, "_donePulse"}, {31'd0, done}, 32'd0);
    check({tag, "_loHeld"}, lo, lastLo);
    check({tag, "_hiHeld"}, hi, lastHi);
  endtask

  task automatic runDiv(input string tag, input logic [31:0] x, input logic [31:0] y);
    startDiv(x, y, 1'b0);
    waitDone(tag);
    doneDrops(tag);
  endtask

  task automatic zeroDiv(input string tag, input logic [31:0] x);
    a = x;
    b = 32'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_divZero"}, {31'd0, div_zero}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    tick();
    check({tag, "_divZeroPulse"}, {31'd0, div_zero}, 32'd0);
    check({tag, "_done2"}, {31'd0, done}, 32'd0);
    check({tag, "_lo"}, lo, lastLo);
    check({tag, "_hi"}, hi, lastHi);
  endtask

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    int          mode;

    reset = 1'b1;
    start = 1'b0;
    a = 32'd0;
    b = 32'd0;
    #3;
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_divZero", {31'd0, div_zero}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    runDiv("d100by7", 32'd100, 32'd7);
    check("d100by7_lo_const", lo, 32'd14);
    check("d100by7_hi_const", hi, 32'd2);
    zeroDiv("zeroAfter100by7", 32'd5);
    runDiv("negBy2", 32'hFFFF_FFF9, 32'd2);
    check("negBy2_lo_const", lo, 32'hFFFF_FFFD);
    check("negBy2_hi_const", hi, 32'hFFFF_FFFF);
    runDiv("posByNeg2", 32'd7, 32'hFFFF_FFFE);
    check("posByNeg2_lo_const", lo, 32'hFFFF_FFFD);
    check("posByNeg2_hi_const", hi, 32'd1);
    runDiv("minByNeg1", 32'h8000_0000, 32'hFFFF_FFFF);
    check("minByNeg1_lo_const", lo, 32'h8000_0000);
    check("minByNeg1_hi_const", hi, 32'd0);

    // start held high: the next division begins on the edge right after done.
    startDiv(32'd1000, 32'd33, 1'b1);
    waitDone("b2bFirst");
    a = 32'hFFFF_FC18;
    b = 32'd7;
    expQ.push_back(refDiv(a, b));
    tick();
    start = 1'b0;
    check("b2bRestart_busy", {31'd0, busy}, 32'd1);
    check("b2bRestart_done", {31'd0, done}, 32'd0);
    waitDone("b2bSecond");
    doneDrops("b2bSecond");

    // Abort: overlapping start while busy, then reset mid-run.
    startDiv(32'd100, 32'd7, 1'b0);
    repeat (4) tick();
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("abort_stillBusy", {31'd0, busy}, 32'd1);
    repeat (5) tick();
    reset = 1'b1;
    #1;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_divZero", {31'd0, div_zero}, 32'd0);
    expQ.delete();
    lastHi = 32'd0;
    lastLo = 32'd0;
    repeat (3) begin
      tick();
      check("abort_noDone", {31'd0, done}, 32'd0);
    end
    reset = 1'b0;
    tick();
    runDiv("after_abort", 32'd9, 32'd3);
    check("after_abort_lo_const", lo, 32'd3);
    check("after_abort_hi_const", hi, 32'd0);

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 5);
      x = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case (mode)
        0: y = 32'd0;
        1: y = $urandom_range(1, 15);
        2: y = -$urandom_range(1, 15);
        3: y = 32'hFFFF_FFFF;
        default: y = $urandom;
      endcase
      if (y == 32'd0) zeroDiv("rand_zero", x);
      else runDiv("rand", x, y);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
